// File: rtl/ysyx_22050019_ifu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050019_ifu
//  Brief    : Instruction fetch unit. Issues one fetch at a time to the
//             icache, selects the 32-bit instruction out of the returned
//             doubleword and hands it to decode. Redirects from the backend
//             either flush the in-flight response or retarget the PC directly.
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_22050019_ifu #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 64'h0000_0000_8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  // icache address channel
  output logic                  ar_valid_o,
  input  logic                  ar_ready_i,
  output logic [ADDR_WIDTH-1:0] ar_addr_o,
  // icache data channel
  input  logic                  r_data_valid_i,
  output logic                  r_data_ready_o,
  input  logic [1:0]            r_resp_i,
  input  logic [DATA_WIDTH-1:0] r_data_i,
  // backend redirect
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  // decode interface
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [31:0]           inst_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  fetch_err_o
);

  typedef enum logic [1:0] {
    S_AR  = 2'd0,   // presenting fetch address
    S_R   = 2'd1,   // waiting for icache data
    S_OUT = 2'd2    // holding instruction for decode
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] C_PC_STEP = ADDR_WIDTH'(4);
  localparam logic [1:0]            C_RESP_OKAY = 2'b00;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_nxt;
  logic                  r_pend;
  logic                  w_pend_nxt;
  logic [ADDR_WIDTH-1:0] r_pend_pc;
  logic [ADDR_WIDTH-1:0] w_pend_pc_nxt;
  logic                  w_out_load;

  logic [31:0]           r_inst;
  logic [ADDR_WIDTH-1:0] r_pc_o;
  logic                  r_err;
  logic [31:0]           w_inst_sel;

  // Upper or lower word of the aligned doubleword, chosen by PC bit 2.
  assign w_inst_sel = r_pc[2] ? r_data_i[63:32] : r_data_i[31:0];

  // Next-state, next-PC and pending-redirect bookkeeping.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pend_nxt    = r_pend;
    w_pend_pc_nxt = r_pend_pc;
    w_out_load    = 1'b0;
    case (r_state)
      S_AR: begin
        // The address must not move while offered, so a redirect here is
        // parked; the outstanding request runs to completion and is dropped.
        if (redirect_valid_i) begin
          w_pend_nxt    = 1'b1;
          w_pend_pc_nxt = redirect_pc_i;
        end
        if (ar_ready_i) begin
          w_state_nxt = S_R;
        end
      end
      S_R: begin
        if (redirect_valid_i) begin
          w_pend_nxt    = 1'b1;
          w_pend_pc_nxt = redirect_pc_i;
        end
        if (r_data_valid_i) begin
          if (r_pend || redirect_valid_i) begin
            // Stale response: discard and restart at the newest target.
            w_state_nxt = S_AR;
            w_pc_nxt    = redirect_valid_i ? redirect_pc_i : r_pend_pc;
            w_pend_nxt  = 1'b0;
          end else begin
            w_out_load  = 1'b1;
            w_state_nxt = S_OUT;
          end
        end
      end
      S_OUT: begin
        // A redirect wins over a simultaneous decode handshake.
        if (redirect_valid_i) begin
          w_pc_nxt    = redirect_pc_i;
          w_state_nxt = S_AR;
        end else if (inst_ready_i) begin
          w_pc_nxt    = r_pc + C_PC_STEP;
          w_state_nxt = S_AR;
        end
      end
      default: begin
        w_state_nxt = S_AR;
      end
    endcase
  end

  // Control state: FSM, fetch PC and pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_AR;
      r_pc      <= RESET_PC;
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pend    <= w_pend_nxt;
      r_pend_pc <= w_pend_pc_nxt;
    end
  end

  // Instruction holding registers, loaded when an accepted response lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst <= '0;
      r_pc_o <= '0;
      r_err  <= 1'b0;
    end else if (w_out_load) begin
      r_inst <= w_inst_sel;
      r_pc_o <= r_pc;
      r_err  <= (r_resp_i != C_RESP_OKAY);
    end
  end

  // All outputs come from registered state only.
  assign ar_valid_o     = (r_state == S_AR);
  assign ar_addr_o      = r_pc;
  assign r_data_ready_o = (r_state == S_R);
  assign inst_valid_o   = (r_state == S_OUT);
  assign inst_o         = r_inst;
  assign pc_o           = r_pc_o;
  assign fetch_err_o    = r_err;

endmodule
`default_nettype wire

// File: doc/ysyx_22050019_ifu.md
YSYX_22050019_IFU -- requirements
Module: ysyx_22050019_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, PC and fetch address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, icache read data width.
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port ar_valid_o  output  1  fetch request valid to icache.
REQ-007 SHALL have port ar_ready_i  input  1  icache accepts request.
REQ-008 SHALL have port ar_addr_o  output  ADDR_WIDTH  fetch address (full PC).
REQ-009 SHALL have port r_data_valid_i  input  1  icache data valid.
REQ-010 SHALL have port r_data_ready_o  output  1  IFU accepts icache data.
REQ-011 SHALL have port r_resp_i  input  2  response code; 2'b00 = OKAY.
REQ-012 SHALL have port r_data_i  input  DATA_WIDTH  8-byte-aligned doubleword containing the instruction.
REQ-013 SHALL have port redirect_valid_i  input  1  branch/jump/trap redirect pulse from the backend.
REQ-014 SHALL have port redirect_pc_i  input  ADDR_WIDTH  redirect target, 4-byte aligned.
REQ-015 SHALL have port inst_valid_o  output  1  instruction valid to decode.
REQ-016 SHALL have port inst_ready_i  input  1  decode accepts instruction.
REQ-017 SHALL have port inst_o  output  32  fetched instruction.
REQ-018 SHALL have port pc_o  output  ADDR_WIDTH  PC of inst_o.
REQ-019 SHALL have port fetch_err_o  output  1  r_resp_i was non-OKAY for inst_o.

Function
REQ-020 SHALL implement FSM states S_AR, S_R, S_OUT. State and all outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.
REQ-021 S_AR: ar_valid_o=1 and ar_addr_o=pc. On ar_valid_o&ar_ready_i, go to S_R.
REQ-022 ar_addr_o SHALL stay stable while ar_valid_o=1 and no handshake has occurred, even if a redirect arrives.
REQ-023 S_R: r_data_ready_o=1. On r_data_valid_i&r_data_ready_o:
  - if the response is not flushed, latch the instruction and go to S_OUT;
  - if it is flushed (REQ-027), go to S_AR.
REQ-024 Instruction select: inst_o = pc[2] ? r_data_i[63:32] : r_data_i[31:0], latched together with pc_o=pc and fetch_err_o=(r_resp_i!=2'b00).
REQ-025 S_OUT: inst_valid_o=1 with inst_o, pc_o and fetch_err_o held stable. On inst_valid_o&inst_ready_i: pc<=pc+4, go to S_AR.
REQ-026 pc+4 SHALL wrap modulo 2^ADDR_WIDTH with no overflow flag.
REQ-027 Redirect in S_AR before the address handshake: the redirect target is stored in a pending register with pending flag=1, and the current request completes. Redirect in S_R, or in the same cycle as the S_AR address handshake: pending flag=1 likewise.
REQ-028 When a response arrives with pending flag=1, the data SHALL be discarded (no inst_valid_o), and pc<=pending target, flag<=0, next state S_AR.
REQ-029 Redirect in S_OUT: inst_valid_o deasserts the next cycle, pc<=redirect_pc_i, go to S_AR. This applies even if inst_ready_i=1 in the same cycle; the redirect has priority and pc+4 is not applied.
REQ-030 A second redirect while pending flag=1 SHALL overwrite the pending target (last redirect wins).
REQ-031 Best-case latency: address handshake in cycle N, data in N+1, inst_valid_o=1 in N+2.
REQ-032 fetch_err_o does not stall the FSM; the faulting instruction is handed over like any other.

Reset
REQ-033 During rst=1: state<=S_AR, pc<=RESET_PC, pending flag<=0.
REQ-034 Output reset values: ar_valid_o=1 in the first cycle after rst deasserts; ar_addr_o=RESET_PC; r_data_ready_o=0; inst_valid_o=0; inst_o=0; pc_o=0; fetch_err_o=0.
REQ-035 rst asserted mid-transaction SHALL abandon it immediately; a late icache response after reset is not accepted, since r_data_ready_o=0 in S_AR.

Verification
REQ-036 Reset then icache ready every cycle, data 64'h00100093_00000013 at 0x8000_0000 -> inst_o=0x00000013 at pc_o=0x8000_0000, then inst_o=0x00100093 at pc_o=0x8000_0004.
REQ-037 inst_ready_i=0 for 5 cycles in S_OUT -> inst_o, pc_o and inst_valid_o stable; no new ar_valid_o until the handshake.
REQ-038 Redirect to 0x8000_0100 while in S_R -> the pending response is dropped and the next ar_addr_o=0x8000_0100.
REQ-039 Redirect to 0x8000_0200 in the same cycle as inst handshake at pc 0x8000_0010 -> next ar_addr_o=0x8000_0200, not 0x8000_0014.
REQ-040 r_resp_i=2'b10 -> fetch_err_o=1 with inst_valid_o. pc=0xFFFF_FFFF_FFFF_FFFC handshake -> next ar_addr_o=0.
REQ-041 rst pulse while in S_R -> next cycle ar_addr_o=RESET_PC, inst_valid_o=0.
